// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, with single-edge fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_din,
    input  logic [XLEN-1:0] rs2_din,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            CW   = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       counter_q, counter_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                accept;
    logic                a_signed, b_signed;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     mul_addend;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift, div_sub;
    logic                div_ge;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   step_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix;
    logic [XLEN-1:0]     final_val;

    // Operand conditioning on the accepting edge
    always_comb begin
        accept   = start && (state_q != S_CALC);
        a_signed = rs1_din[XLEN-1] &&
                   (funct3 == F_MULH || funct3 == F_MULHSU || funct3 == F_DIV || funct3 == F_REM);
        b_signed = rs2_din[XLEN-1] &&
                   (funct3 == F_MULH || funct3 == F_DIV || funct3 == F_REM);
        a_mag    = a_signed ? ('0 - rs1_din) : rs1_din;
        b_mag    = b_signed ? ('0 - rs2_din) : rs2_din;
        div_zero = funct3[2] && (rs2_din == '0);
        div_ovf  = funct3[2] && !funct3[0] &&
                   (rs1_din == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_din == '1);
    end

    // One iteration step. Multiply keeps {product_hi, multiplier} in acc and shifts right;
    // divide keeps {remainder, dividend/quotient} in acc and shifts left.
    always_comb begin
        mul_addend = acc_q[0] ? opa_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};

        div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge     = div_shift >= {1'b0, opb_q};
        div_sub    = div_shift - {1'b0, opb_q};
        div_next   = {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

        step_next  = op_q[2] ? div_next : mul_next;

        prod_fix   = neg_q ? ('0 - step_next) : step_next;
        quot_fix   = neg_q ? ('0 - step_next[XLEN-1:0]) : step_next[XLEN-1:0];
        rem_fix    = neg_q ? ('0 - step_next[2*XLEN-1:XLEN]) : step_next[2*XLEN-1:XLEN];

        if (op_q == F_MUL) begin
            final_val = step_next[XLEN-1:0];
        end else if (!op_q[2]) begin
            final_val = prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            final_val = quot_fix;
        end else begin
            final_val = rem_fix;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        counter_d = counter_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_CALC: begin
                acc_d     = step_next;
                counter_d = counter_q + CW'(1);
                if (counter_q == LAST) begin
                    result_d = final_val;
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            op_d      = funct3;
            opa_d     = a_mag;
            opb_d     = b_mag;
            counter_d = '0;
            if (funct3[2] && funct3[1]) begin
                neg_d = a_signed;
            end else if (funct3 == F_MULHSU) begin
                neg_d = a_signed;
            end else begin
                neg_d = a_signed ^ b_signed;
            end
            if (div_zero) begin
                result_d = funct3[1] ? rs1_din : '1;
                state_d  = S_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end else if (div_ovf) begin
                result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                state_d  = S_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end else begin
                acc_d   = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                state_d = S_CALC;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            counter_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            counter_q <= counter_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result and latency are queued at issue
// and popped when done is observed.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_din;
    logic [31:0] rs2_din;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .STEPS(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .rs1_din (rs1_din),
        .rs2_din (rs2_din),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (f)
            3'd0: p = sa * sb;
            3'd1: begin p = sa * sb; p = p >>> 32; end
            3'd2: begin p = sa * ub; p = p >>> 32; end
            3'd3: begin p = ua * ub; p = p >> 32; end
            3'd4: p = (b == 0) ? -1 : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? sa : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input int lat);
        @(negedge clk);
        start   = 1'b1;
        funct3  = f;
        rs1_din = a;
        rs2_din = b;
        exp_q.push_back(e);
        lat_q.push_back(lat);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; reports what was observed without judging it.
    task automatic collect(input int edges0, output logic [31:0] res, output int edges,
                           output bit busy_ok, output bit seen);
        edges   = edges0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        seen = (done === 1'b1);
        if (busy !== 1'b0) busy_ok = 1'b0;
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith();
        vec_t        v[9];
        logic [31:0] res, e;
        int          edges, l;
        bit          bok, seen;
        v[0] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        v[5] = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        v[6] = '{3'd5, 32'd100,       32'd7,         32'd14};
        v[7] = '{3'd7, 32'd100,       32'd7,         32'd2};
        v[8] = '{3'd1, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF};
        for (int i = 0; i < 9; i++) begin
            issue_op(v[i].f, v[i].a, v[i].b, v[i].e, 33);
            collect(1, res, edges, bok, seen);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            $display("arith f=%0d a=%h b=%h -> %h after %0d edges", v[i].f, v[i].a, v[i].b, res, edges);
            checks++; if (!seen || res !== e) begin errors++; $display("FAIL arith_result[%0d]: got %h expected %h", i, res, e); end
            checks++; if (edges !== l) begin errors++; $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, edges, l); end
            checks++; if (!bok) begin errors++; $display("FAIL arith_busy[%0d]: busy wrong during op or with done", i); end
        end
    endtask

    task automatic test_fast_paths();
        vec_t        v[4];
        logic [31:0] res, e;
        int          edges, l;
        bit          bok, seen;
        v[0] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{3'd6, 32'd5,         32'd0,         32'd5};
        v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue_op(v[i].f, v[i].a, v[i].b, v[i].e, 1);
            collect(1, res, edges, bok, seen);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            $display("fast f=%0d a=%h b=%h -> %h after %0d edges", v[i].f, v[i].a, v[i].b, res, edges);
            checks++; if (!seen || res !== e) begin errors++; $display("FAIL fast_result[%0d]: got %h expected %h", i, res, e); end
            checks++; if (edges !== l) begin errors++; $display("FAIL fast_latency[%0d]: got %0d expected %0d", i, edges, l); end
            checks++; if (!bok) begin errors++; $display("FAIL fast_busy[%0d]: busy high on fast path", i); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, e;
        int          edges, l;
        bit          bok, seen;
        for (int i = 0; i < 20; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 7 == 3) b = 32'd0;
            if (i % 5 == 1) b = 32'(b >> $urandom_range(0, 31));
            issue_op(f, a, b, model(f, a, b), model_lat(f, a, b));
            collect(1, res, edges, bok, seen);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            $display("random f=%0d a=%h b=%h -> %h after %0d edges", f, a, b, res, edges);
            checks++; if (!seen || res !== e) begin errors++; $display("FAIL random_result[%0d]: got %h expected %h", i, res, e); end
            checks++; if (edges !== l) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, edges, l); end
            checks++; if (!bok) begin errors++; $display("FAIL random_busy[%0d]: busy wrong during op or with done", i); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res, e;
        int          edges, l;
        bit          bok, seen;
        issue_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        repeat (8) @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        funct3  = 3'd5;
        rs1_din = 32'd5;
        rs2_din = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        collect(10, res, edges, bok, seen);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        $display("ignore_start: MUL with start at edge 10 -> %h after %0d edges", res, edges);
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL ignore_result: got %h expected %h", res, e); end
        checks++; if (edges !== l) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", edges, l); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_no_extra: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, e, held;
        int          edges, l;
        bit          bok, seen;
        issue_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        collect(1, res, edges, bok, seen);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        $display("b2b first: MULHU -> %h after %0d edges", res, edges);
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL b2b_first: got %h expected %h", res, e); end
        // issue_op drives start in the DONE cycle, so it is accepted back-to-back
        issue_op(3'd5, 32'd100, 32'd7, 32'd14, 33);
        collect(1, res, edges, bok, seen);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        $display("b2b second: DIVU 100/7 -> %h after %0d edges", res, edges);
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL b2b_second: got %h expected %h", res, e); end
        checks++; if (edges !== l) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", edges, l); end
        held = res;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (result !== held) begin errors++; $display("FAIL result_hold: got %h expected %h", result, held); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, e, drop_e;
        int          edges, l, drop_l;
        bit          bok, seen, saw_done;
        issue_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        repeat (13) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drop_e = exp_q.pop_back();
        drop_l = lat_q.pop_back();
        $display("reset_mid: dropped pending %h (lat %0d), busy=%b done=%b result=%h", drop_e, drop_l, busy, done, result);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL mid_reset_result: got %h expected 00000000", result); end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL mid_reset_no_done: got done pulse expected none"); end
        issue_op(3'd7, 32'd100, 32'd7, 32'd2, 33);
        collect(1, res, edges, bok, seen);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        $display("after reset: REMU 100/7 -> %h after %0d edges", res, edges);
        checks++; if (!seen || res !== e) begin errors++; $display("FAIL post_reset_result: got %h expected %h", res, e); end
        checks++; if (edges !== l) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", edges, l); end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_din = 32'd0;
        rs2_din = 32'd0;
        test_reset();
        test_arith();
        test_fast_paths();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
